// File: rtl/regfile_mp_sb_if.sv
// Purpose : bundles the read, write, allocation and flush signals of the multi-port register file.
// Latency : wires only; the interface holds no state.
// Backpr. : none; every port is used on every cycle it is driven.
// Ports   : master = issue/writeback side (drives addresses, write data, alloc, flush);
//           slave  = register file (drives read data, busy bits, write-conflict pulse).
interface regfile_mp_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic [NWR-1:0]      wr_en_i;
    logic [NWR*AW-1:0]   wr_addr_i;
    logic [NWR*XLEN-1:0] wr_data_i;
    logic                alloc_en_i;
    logic [AW-1:0]       alloc_addr_i;
    logic                flush_i;
    logic                wr_conflict_o;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
        input  rd_data_o, rd_busy_o, wr_conflict_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
        output rd_data_o, rd_busy_o, wr_conflict_o
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Purpose : RV32I integer register file, NRD combinational reads, NWR writes, per-register busy scoreboard.
// Latency : reads 0 cycles; writes and scoreboard updates visible 1 cycle after the edge
//           (same cycle for write data/busy release when REGFILE_BYPASS_EN is defined).
// Backpr. : none; all writes, allocs and flushes are accepted every cycle.
// Ports   : clock, reset (synchronous, active-high); bus = regfile_mp_sb_if.slave carrying
//           rd_addr_i/rd_data_o/rd_busy_o, wr_en_i/wr_addr_i/wr_data_i, alloc_en_i/alloc_addr_i,
//           flush_i and the registered wr_conflict_o pulse.
// Option  : `define REGFILE_BYPASS_EN to forward same-cycle write data and busy release to reads.
module regfile_mp_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic             clock,
    input  logic             reset,
    regfile_mp_sb_if.slave   bus
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            conflict_q, conflict_d;

    // Unpacked views of the flat write buses.
    logic [AW-1:0]   wr_addr [NWR];
    logic [XLEN-1:0] wr_dat  [NWR];
    logic [NWR-1:0]  wr_en;

    for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
        assign wr_addr[j] = bus.wr_addr_i[j*AW +: AW];
        assign wr_dat[j]  = bus.wr_data_i[j*XLEN +: XLEN];
        assign wr_en[j]   = bus.wr_en_i[j];
    end

    // Ports are scanned in ascending order, so the highest-index enabled port wins a collision.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j] != '0)) begin
                regs_d[wr_addr[j]] = wr_dat[j];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard: flush beats alloc, alloc beats a same-cycle write (new producer supersedes old).
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j]] = 1'b0;
            end
        end
        if (bus.alloc_en_i) begin
            busy_d[bus.alloc_addr_i] = 1'b1;
        end
        if (bus.flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Any pair of enabled ports aimed at the same nonzero register.
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_addr[i] == wr_addr[j]) && (wr_addr[i] != '0)) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.wr_conflict_o = conflict_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data;
        logic            busy;

        assign ra = bus.rd_addr_i[k*AW +: AW];

        always_comb begin
            // x0 is forced here so it reads zero even before the first reset edge.
            data = (ra == '0) ? '0 : regs_q[ra];
            busy = (ra == '0) ? 1'b0 : busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            // Writes are ignored under reset, so they must not be forwarded either.
            for (int j = 0; j < NWR; j++) begin
                if (!reset && wr_en[j] && (wr_addr[j] == ra) && (ra != '0)) begin
                    data = wr_dat[j];
                    if (!(bus.alloc_en_i && (bus.alloc_addr_i == ra))) begin
                        busy = 1'b0;
                    end
                end
            end
`endif
        end

        assign bus.rd_data_o[k*XLEN +: XLEN] = data;
        assign bus.rd_busy_o[k]              = busy;
    end

endmodule
